// File: rtl/pipe_os_rx_gen.sv
// PIPE receive-side ordered-set generator: SKP / TS1 / TS2 on NUM_LANES lanes, DATA_BYTES symbols per lane per clock.
// Defining OSGEN_SKP_INSERT_EN adds a periodic SKP OS inserted every SKP_INTERVAL clocks at OS boundaries.
module pipe_os_rx_gen #(
  parameter int NUM_LANES    = 1,
  parameter int DATA_BYTES   = 1,
  parameter int SKP_INTERVAL = 1180
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en_n,
  input  logic                                start,
  input  logic [1:0]                          os_sel,
  input  logic [15:0]                         os_count,
  input  logic [39:0]                         ts_bytes1to5,
  output logic                                busy,
  output logic                                os_done,
  output logic                                seq_done,
  output logic [NUM_LANES*DATA_BYTES*8-1:0]   rxdata,
  output logic [NUM_LANES*DATA_BYTES-1:0]     rxdatak,
  output logic [NUM_LANES-1:0]                rxvalid
);

  localparam logic [4:0] STEP    = 5'(DATA_BYTES);
  localparam logic [1:0] SEL_SKP = 2'd1;
  localparam logic [1:0] SEL_TS2 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1
`ifdef OSGEN_SKP_INSERT_EN
    , ST_SKP_INS = 2'd2
`endif
  } state_t;

  state_t      r_state, w_nxt_state;
  logic [4:0]  r_ptr, w_nxt_ptr;
  logic [1:0]  r_sel, w_nxt_sel;
  logic [15:0] r_count, w_nxt_count;
  logic [15:0] r_sent, w_nxt_sent;
  logic [39:0] r_snap, w_nxt_snap;

  logic w_cur_skp, w_last, w_stop, w_final, w_start, w_skp_pend;
  logic w_nxt_busy, w_nxt_skp, w_nxt_os_done, w_nxt_seq_done;
  logic [NUM_LANES*DATA_BYTES*8-1:0] w_nxt_data;
  logic [NUM_LANES*DATA_BYTES-1:0]   w_nxt_datak;

  logic                                r_busy, r_os_done, r_seq_done;
  logic [NUM_LANES*DATA_BYTES*8-1:0]   r_rxdata;
  logic [NUM_LANES*DATA_BYTES-1:0]     r_rxdatak;
  logic [NUM_LANES-1:0]                r_rxvalid;

  function automatic logic [4:0] os_len(input logic skp);
    return skp ? 5'd4 : 5'd16;
  endfunction

  // Returns {K flag, symbol} for symbol index idx of the current OS on the given lane.
  function automatic logic [8:0] sym_f(input logic [4:0] idx, input logic skp, input logic ts2,
                                       input logic [39:0] snap, input logic [7:0] lane);
    logic [7:0] b;
    logic [8:0] r;
    b = 8'h00;
    r = 9'h000;
    if (idx == 5'd0) begin
      r = {1'b1, 8'hBC};
    end else if (skp) begin
      r = {1'b1, 8'h1C};
    end else if (idx <= 5'd5) begin
      case (idx)
        5'd1:    b = snap[7:0];
        5'd2:    b = snap[15:8];
        5'd3:    b = snap[23:16];
        5'd4:    b = snap[31:24];
        default: b = snap[39:32];
      endcase
      if (b == 8'hF7) begin
        r = {1'b1, 8'hF7};
      end else if (idx == 5'd2) begin
        r = {1'b0, 8'(b + lane)};
      end else begin
        r = {1'b0, b};
      end
    end else begin
      r = {1'b0, (ts2 ? 8'h45 : 8'h4A)};
    end
    return r;
  endfunction

`ifdef OSGEN_SKP_INSERT_EN
  logic [15:0] r_skp_cnt;
  logic        r_skp_pend;
  logic        w_skp_done;

  assign w_cur_skp  = (r_sel == SEL_SKP) || (r_state == ST_SKP_INS);
  assign w_nxt_skp  = (w_nxt_sel == SEL_SKP) || (w_nxt_state == ST_SKP_INS);
  // A requested SKP OS also satisfies a pending insertion.
  assign w_skp_pend = r_skp_pend && !w_cur_skp;
  assign w_skp_done = (r_state != ST_IDLE) && w_cur_skp && w_last;

  // Busy-time clock counter that raises a pending SKP request.
  always_ff @(posedge clk) begin
    if (rst || !r_busy || w_skp_done) begin
      r_skp_cnt  <= 16'd0;
      r_skp_pend <= 1'b0;
    end else if (!r_skp_pend) begin
      if (r_skp_cnt == 16'(SKP_INTERVAL - 1)) begin
        r_skp_pend <= 1'b1;
      end else begin
        r_skp_cnt <= r_skp_cnt + 16'd1;
      end
    end
  end
`else
  logic w_unused_skp_interval;

  assign w_unused_skp_interval = (SKP_INTERVAL > 0);
  assign w_cur_skp  = (r_sel == SEL_SKP);
  assign w_nxt_skp  = (w_nxt_sel == SEL_SKP);
  assign w_skp_pend = 1'b0;
`endif

  assign w_last  = ((r_ptr + STEP) == os_len(w_cur_skp));
  assign w_stop  = en_n || (os_sel == 2'd0);
  assign w_final = (r_count != 16'd0) && ((r_sent + 16'd1) == r_count);
  assign w_start = start && !en_n && (os_sel != 2'd0);

  // Next-beat sequencing: state, symbol pointer and OS bookkeeping.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ptr   = r_ptr;
    w_nxt_sel   = r_sel;
    w_nxt_count = r_count;
    w_nxt_sent  = r_sent;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_nxt_state = ST_SEND;
          w_nxt_ptr   = 5'd0;
          w_nxt_sel   = os_sel;
          w_nxt_count = os_count;
          w_nxt_sent  = 16'd0;
        end else begin
          w_nxt_ptr = 5'd0;
        end
      end
      ST_SEND: begin
        if (!w_last) begin
          w_nxt_ptr = r_ptr + STEP;
        end else begin
          w_nxt_ptr  = 5'd0;
          w_nxt_sent = r_sent + 16'd1;
          if (w_final) begin
            w_nxt_state = ST_IDLE;
`ifdef OSGEN_SKP_INSERT_EN
          end else if (w_skp_pend) begin
            w_nxt_state = ST_SKP_INS;
`endif
          end else if (w_stop) begin
            w_nxt_state = ST_IDLE;
          end else begin
            w_nxt_state = ST_SEND;
          end
        end
      end
`ifdef OSGEN_SKP_INSERT_EN
      ST_SKP_INS: begin
        if (!w_last) begin
          w_nxt_ptr = r_ptr + STEP;
        end else begin
          w_nxt_ptr = 5'd0;
          if (w_stop) begin
            w_nxt_state = ST_IDLE;
          end else begin
            w_nxt_state = ST_SEND;
          end
        end
      end
`endif
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_ptr   = 5'd0;
      end
    endcase
  end

  assign w_nxt_busy     = (w_nxt_state != ST_IDLE);
  assign w_nxt_snap     = (w_nxt_busy && (w_nxt_ptr == 5'd0)) ? ts_bytes1to5 : r_snap;
  assign w_nxt_os_done  = (w_nxt_state == ST_SEND) &&
                          ((w_nxt_ptr + STEP) == os_len(w_nxt_sel == SEL_SKP));
  assign w_nxt_seq_done = w_nxt_os_done && (w_nxt_count != 16'd0) &&
                          ((w_nxt_sent + 16'd1) == w_nxt_count);

  // Symbol bus for the next beat; all zero when the next beat is idle.
  always_comb begin
    w_nxt_data  = '0;
    w_nxt_datak = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int k = 0; k < DATA_BYTES; k++) begin
        {w_nxt_datak[l*DATA_BYTES+k], w_nxt_data[(l*DATA_BYTES+k)*8 +: 8]} =
          w_nxt_busy ? sym_f(w_nxt_ptr + 5'(k), w_nxt_skp, (w_nxt_sel == SEL_TS2), w_nxt_snap, 8'(l))
                     : 9'h000;
      end
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 5'd0;
      r_sel      <= 2'd0;
      r_count    <= 16'd0;
      r_sent     <= 16'd0;
      r_snap     <= 40'd0;
      r_busy     <= 1'b0;
      r_os_done  <= 1'b0;
      r_seq_done <= 1'b0;
      r_rxdata   <= '0;
      r_rxdatak  <= '0;
      r_rxvalid  <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_ptr      <= w_nxt_ptr;
      r_sel      <= w_nxt_sel;
      r_count    <= w_nxt_count;
      r_sent     <= w_nxt_sent;
      r_snap     <= w_nxt_snap;
      r_busy     <= w_nxt_busy;
      r_os_done  <= w_nxt_os_done;
      r_seq_done <= w_nxt_seq_done;
      r_rxdata   <= w_nxt_data;
      r_rxdatak  <= w_nxt_datak;
      r_rxvalid  <= {NUM_LANES{w_nxt_busy}};
    end
  end

  assign busy     = r_busy;
  assign os_done  = r_os_done;
  assign seq_done = r_seq_done;
  assign rxdata   = r_rxdata;
  assign rxdatak  = r_rxdatak;
  assign rxvalid  = r_rxvalid;

endmodule

// File: tb/tb_pipe_os_rx_gen.sv
// Directed self-checking bench for pipe_os_rx_gen: three widths (1x1, 2x2, 4x4) driven from shared inputs.
module tb_pipe_os_rx_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en_n, start;
  logic [1:0]  os_sel;
  logic [15:0] os_count;
  logic [39:0] ts;

  logic         c1_busy, c1_os_done, c1_seq_done;
  logic [7:0]   c1_rxdata;
  logic [0:0]   c1_rxdatak, c1_rxvalid;
  logic         c2_busy, c2_os_done, c2_seq_done;
  logic [31:0]  c2_rxdata;
  logic [3:0]   c2_rxdatak;
  logic [1:0]   c2_rxvalid;
  logic         c4_busy, c4_os_done, c4_seq_done;
  logic [127:0] c4_rxdata;
  logic [15:0]  c4_rxdatak;
  logic [3:0]   c4_rxvalid;

  int n_checks;
  int n_fail;

  pipe_os_rx_gen #(.NUM_LANES(1), .DATA_BYTES(1), .SKP_INTERVAL(20)) u1 (
    .clk(clk), .rst(rst), .en_n(en_n), .start(start), .os_sel(os_sel), .os_count(os_count),
    .ts_bytes1to5(ts), .busy(c1_busy), .os_done(c1_os_done), .seq_done(c1_seq_done),
    .rxdata(c1_rxdata), .rxdatak(c1_rxdatak), .rxvalid(c1_rxvalid));

  pipe_os_rx_gen #(.NUM_LANES(2), .DATA_BYTES(2), .SKP_INTERVAL(1180)) u2 (
    .clk(clk), .rst(rst), .en_n(en_n), .start(start), .os_sel(os_sel), .os_count(os_count),
    .ts_bytes1to5(ts), .busy(c2_busy), .os_done(c2_os_done), .seq_done(c2_seq_done),
    .rxdata(c2_rxdata), .rxdatak(c2_rxdatak), .rxvalid(c2_rxvalid));

  pipe_os_rx_gen #(.NUM_LANES(4), .DATA_BYTES(4), .SKP_INTERVAL(1180)) u4 (
    .clk(clk), .rst(rst), .en_n(en_n), .start(start), .os_sel(os_sel), .os_count(os_count),
    .ts_bytes1to5(ts), .busy(c4_busy), .os_done(c4_os_done), .seq_done(c4_seq_done),
    .rxdata(c4_rxdata), .rxdatak(c4_rxdatak), .rxvalid(c4_rxvalid));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    int k;
    start  = 1'b0;
    en_n   = 1'b1;
    os_sel = 2'd0;
    k = 0;
    while ((c1_busy || c2_busy || c4_busy) && k < 60) begin
      tick();
      k++;
    end
    n_checks++;
    if (c1_busy || c2_busy || c4_busy) begin
      n_fail++;
      $display("FAIL drain: busy=%b%b%b after %0d cycles, expected 000", c1_busy, c2_busy, c4_busy, k);
    end
    tick();
    en_n = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en_n = 1'b1; start = 1'b0; os_sel = 2'd0; os_count = 16'd0; ts = 40'd0;
    tick();
    tick();
    n_checks++;
    if ({c1_busy, c1_os_done, c1_seq_done, c1_rxdata, c1_rxdatak, c1_rxvalid} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_u1: got %h expected 0", {c1_busy, c1_os_done, c1_seq_done, c1_rxdata, c1_rxdatak, c1_rxvalid});
    end
    n_checks++;
    if ({c2_busy, c2_os_done, c2_seq_done, c2_rxdata, c2_rxdatak, c2_rxvalid} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_u2: got %h expected 0", {c2_busy, c2_os_done, c2_seq_done, c2_rxdata, c2_rxdatak, c2_rxvalid});
    end
    n_checks++;
    if ({c4_busy, c4_os_done, c4_seq_done, c4_rxdata, c4_rxdatak, c4_rxvalid} !== 151'd0) begin
      n_fail++;
      $display("FAIL reset_u4: got %h expected 0", {c4_busy, c4_os_done, c4_seq_done, c4_rxdata, c4_rxdatak, c4_rxvalid});
    end
    rst = 1'b0; en_n = 1'b0;
    tick();
  endtask

  task automatic test_ts1_counted;
    logic [7:0] exp_sym [16];
    exp_sym = '{8'hBC, 8'h01, 8'hF7, 8'h18, 8'h02, 8'h0A, 8'h4A, 8'h4A,
                8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A};
    os_sel = 2'd2; os_count = 16'd2; ts = 40'h0A_02_18_F7_01; start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 1; b <= 32; b++) begin
      int i;
      logic [12:0] e, g;
      i = (b - 1) % 16;
      e = {1'b1, 1'b1, (i == 0 || i == 2), exp_sym[i], (i == 15), (b == 32)};
      g = {c1_rxvalid, c1_busy, c1_rxdatak, c1_rxdata, c1_os_done, c1_seq_done};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL ts1_beat%0d {valid,busy,k,data,os_done,seq_done}: got %h expected %h", b, g, e);
      end
      tick();
    end
    n_checks++;
    if ({c1_rxvalid, c1_busy, c1_rxdata} !== 10'd0) begin
      n_fail++;
      $display("FAIL ts1_idle_after: got %h expected 0", {c1_rxvalid, c1_busy, c1_rxdata});
    end
  endtask

  task automatic test_multilane;
    drain();
    for (int rep = 0; rep < 2; rep++) begin
      os_sel = 2'd3; os_count = 16'd1; start = 1'b1;
      ts = (rep == 1) ? 40'h55_44_33_F7_11 : 40'h55_44_33_00_11;
      tick();
      start = 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (b == 0) ts = 40'hAA_BB_CC_DD_EE;
        n_checks++;
        if ({c4_rxvalid, c4_busy, c4_os_done, c4_seq_done} !== {4'hF, 1'b1, (b == 3), (b == 3)}) begin
          n_fail++;
          $display("FAIL ml%0d_ctl_beat%0d: got %b expected %b", rep, b,
                   {c4_rxvalid, c4_busy, c4_os_done, c4_seq_done}, {4'hF, 1'b1, (b == 3), (b == 3)});
        end
        for (int l = 0; l < 4; l++) begin
          logic [31:0] ew;
          logic [3:0]  ek;
          if (b == 0) begin
            ew = {8'h33, ((rep == 1) ? 8'hF7 : 8'(l)), 8'h11, 8'hBC};
            ek = (rep == 1) ? 4'b0101 : 4'b0001;
          end else if (b == 1) begin
            ew = {8'h45, 8'h45, 8'h55, 8'h44};
            ek = 4'b0000;
          end else begin
            ew = 32'h45454545;
            ek = 4'b0000;
          end
          n_checks++;
          if ({c4_rxdatak[l*4 +: 4], c4_rxdata[l*32 +: 32]} !== {ek, ew}) begin
            n_fail++;
            $display("FAIL ml%0d_lane%0d_beat%0d {k,data}: got %h expected %h", rep, l, b,
                     {c4_rxdatak[l*4 +: 4], c4_rxdata[l*32 +: 32]}, {ek, ew});
          end
        end
        tick();
      end
      n_checks++;
      if ({c4_rxvalid, c4_busy, c4_rxdata} !== 133'd0) begin
        n_fail++;
        $display("FAIL ml%0d_idle_after: valid=%b busy=%b", rep, c4_rxvalid, c4_busy);
      end
    end
  endtask

  task automatic test_stop_skp;
    drain();
    os_sel = 2'd1; os_count = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 1; b <= 8; b++) begin
      n_checks++;
      if ({c2_rxvalid, c2_busy, c2_os_done, c2_seq_done} !== {2'b11, 1'b1, (b % 2 == 0), 1'b0}) begin
        n_fail++;
        $display("FAIL skp_ctl_beat%0d: got %b expected %b", b,
                 {c2_rxvalid, c2_busy, c2_os_done, c2_seq_done}, {2'b11, 1'b1, (b % 2 == 0), 1'b0});
      end
      for (int l = 0; l < 2; l++) begin
        logic [17:0] e;
        e = (b % 2 == 1) ? {2'b11, 16'h1CBC} : {2'b11, 16'h1C1C};
        n_checks++;
        if ({c2_rxdatak[l*2 +: 2], c2_rxdata[l*16 +: 16]} !== e) begin
          n_fail++;
          $display("FAIL skp_lane%0d_beat%0d: got %h expected %h", l, b,
                   {c2_rxdatak[l*2 +: 2], c2_rxdata[l*16 +: 16]}, e);
        end
      end
      if (b == 7) os_sel = 2'd0;
      tick();
    end
    n_checks++;
    if ({c2_rxvalid, c2_busy, c2_seq_done, c2_rxdata} !== 36'd0) begin
      n_fail++;
      $display("FAIL skp_stop_idle: got %h expected 0", {c2_rxvalid, c2_busy, c2_seq_done, c2_rxdata});
    end
  endtask

  task automatic test_reset_mid;
    drain();
    os_sel = 2'd2; os_count = 16'd0; ts = 40'h0A_02_18_F7_01; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    n_checks++;
    if ({c1_rxvalid, c1_rxdatak, c1_rxdata} !== {1'b1, 1'b0, 8'h4A}) begin
      n_fail++;
      $display("FAIL rstmid_sym7: got %h expected %h", {c1_rxvalid, c1_rxdatak, c1_rxdata}, {1'b1, 1'b0, 8'h4A});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({c1_rxvalid, c1_busy, c1_rxdata, c1_rxdatak, c1_os_done, c1_seq_done} !== 13'd0) begin
      n_fail++;
      $display("FAIL rstmid_cleared: got %h expected 0",
               {c1_rxvalid, c1_busy, c1_rxdata, c1_rxdatak, c1_os_done, c1_seq_done});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({c1_rxvalid, c1_rxdatak, c1_rxdata} !== {1'b1, 1'b1, 8'hBC}) begin
      n_fail++;
      $display("FAIL rstmid_restart_com: got %h expected %h", {c1_rxvalid, c1_rxdatak, c1_rxdata}, {1'b1, 1'b1, 8'hBC});
    end
    tick();
    n_checks++;
    if ({c1_rxdatak, c1_rxdata} !== {1'b0, 8'h01}) begin
      n_fail++;
      $display("FAIL rstmid_restart_sym1: got %h expected %h", {c1_rxdatak, c1_rxdata}, {1'b0, 8'h01});
    end
  endtask

  task automatic test_ignored_start;
    drain();
    en_n = 1'b1; os_sel = 2'd2; os_count = 16'd1; ts = 40'h0A_02_18_F7_01; start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({c1_rxvalid, c1_busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL ign_en_n_%0d: got %b expected 00", i, {c1_rxvalid, c1_busy});
      end
    end
    en_n = 1'b0; os_sel = 2'd0;
    tick();
    n_checks++;
    if ({c1_rxvalid, c1_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL ign_sel0: got %b expected 00", {c1_rxvalid, c1_busy});
    end
    os_sel = 2'd2;
    tick();
    start = 1'b0;
    for (int s = 1; s <= 15; s++) begin
      start = (s == 3);
      if (s == 3) begin
        os_sel = 2'd3;
        os_count = 16'd5;
      end
      tick();
      if (s == 10) begin
        n_checks++;
        if ({c1_rxdatak, c1_rxdata} !== {1'b0, 8'h4A}) begin
          n_fail++;
          $display("FAIL ign_busy_sym10: got %h expected %h", {c1_rxdatak, c1_rxdata}, {1'b0, 8'h4A});
        end
      end
      if (s == 15) begin
        n_checks++;
        if ({c1_os_done, c1_seq_done} !== 2'b11) begin
          n_fail++;
          $display("FAIL ign_busy_done: got %b expected 11", {c1_os_done, c1_seq_done});
        end
      end
    end
    start = 1'b0;
    tick();
    n_checks++;
    if ({c1_rxvalid, c1_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL ign_busy_end: got %b expected 00", {c1_rxvalid, c1_busy});
    end
  endtask

  task automatic test_back_to_back;
    drain();
    os_sel = 2'd2; os_count = 16'd1; ts = 40'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({c4_busy, c4_os_done, c4_seq_done} !== 3'b111) begin
      n_fail++;
      $display("FAIL b2b_last: got %b expected 111", {c4_busy, c4_os_done, c4_seq_done});
    end
    tick();
    n_checks++;
    if ({c4_rxvalid, c4_busy} !== 5'd0) begin
      n_fail++;
      $display("FAIL b2b_gap: got %b expected 0", {c4_rxvalid, c4_busy});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({c4_rxvalid, c4_busy, c4_rxdatak[0], c4_rxdata[7:0]} !== {4'hF, 1'b1, 1'b1, 8'hBC}) begin
      n_fail++;
      $display("FAIL b2b_restart: got %h expected %h",
               {c4_rxvalid, c4_busy, c4_rxdatak[0], c4_rxdata[7:0]}, {4'hF, 1'b1, 1'b1, 8'hBC});
    end
  endtask

`ifdef OSGEN_SKP_INSERT_EN
  task automatic test_skp_insert;
    logic [7:0] exp_sym [16];
    exp_sym = '{8'hBC, 8'h01, 8'hF7, 8'h18, 8'h02, 8'h0A, 8'h4A, 8'h4A,
                8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A};
    drain();
    os_sel = 2'd2; os_count = 16'd0; ts = 40'h0A_02_18_F7_01; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      int i;
      logic [10:0] e, g;
      if (c < 32 || c >= 36) begin
        i = (c < 32) ? (c % 16) : (c - 36);
        e = {1'b1, (i == 0 || i == 2), exp_sym[i], (c == 15 || c == 31)};
      end else begin
        e = {1'b1, 1'b1, ((c == 32) ? 8'hBC : 8'h1C), 1'b0};
      end
      g = {c1_busy, c1_rxdatak, c1_rxdata, c1_os_done};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL skpins_clk%0d {busy,k,data,os_done}: got %h expected %h", c, g, e);
      end
      tick();
    end
    drain();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_ts1_counted();
    test_multilane();
    test_stop_skp();
    test_reset_mid();
    test_ignored_start();
    test_back_to_back();
`ifdef OSGEN_SKP_INSERT_EN
    test_skp_insert();
`endif
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
